load_store_unit: RTL

//   Memory-access stage downstream of the ALU/EXECUTE stage of the RV32I core.

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: computes rs1+imm, drives a word-addressed memory port,
// builds store lane masks and extends load data, reporting done/err back to the core.
module load_store_unit #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] imm,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data
);

    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE, FAULT} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    state_t      state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        load_q;
    logic [7:0]  wait_cnt;

    logic [31:0] addr_c;
    logic        accept_c;
    logic        legal_c;
    logic        misaligned_c;
    logic [3:0]  wmask_c;
    logic [31:0] wdata_c;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] rd);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = a[1] ? rd[31:16] : rd[15:0];
        b = a[0] ? h[15:8] : h[7:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    always_comb begin
        addr_c       = rs1 + imm;
        accept_c     = start && (is_load ^ is_store);
        legal_c      = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                               : (funct3 inside {3'b000, 3'b001, 3'b010});
        misaligned_c = (funct3[1:0] == 2'b01 && addr_c[0]) ||
                       (funct3[1:0] == 2'b10 && addr_c[1:0] != 2'b00);
        case (funct3[1:0])
            2'b00: begin
                wmask_c = 4'b0001 << addr_c[1:0];
                wdata_c = {4{rs2[7:0]}};
            end
            2'b01: begin
                wmask_c = addr_c[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{rs2[15:0]}};
            end
            default: begin
                wmask_c = 4'b1111;
                wdata_c = rs2;
            end
        endcase
    end

    // Outputs are registered on entry to each state; done/err default low so they pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_q    <= '0;
            funct3_q  <= '0;
            load_q    <= 1'b0;
            wait_cnt  <= '0;
            mem_addr  <= '0;
            mem_rstrb <= 1'b0;
            mem_wmask <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        addr_q   <= addr_c;
                        funct3_q <= funct3;
                        load_q   <= is_load;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                        if (!legal_c || misaligned_c) begin
                            state <= FAULT;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            mem_addr  <= {addr_c[31:2], 2'b00};
                            mem_rstrb <= is_load;
                            mem_wmask <= is_store ? wmask_c : 4'b0000;
                            mem_wdata <= is_store ? wdata_c : 32'd0;
                        end
                    end
                end
                ACCESS, WAIT: begin
                    mem_rstrb <= 1'b0;
                    mem_wmask <= '0;
                    if (mem_ready) begin
                        if (load_q) begin
                            load_data <= extract(funct3_q, addr_q[1:0], mem_rdata);
                        end
                        state     <= DONE;
                        done      <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt + 8'd1 == MAX_CNT) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            mem_addr  <= '0;
                            mem_wdata <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                DONE, FAULT: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    wait_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
